mac_rx: RTL and testbench
=========================

MAC_RX -- requirements
Module: mac_rx

Interface
REQ-001 SHALL have parameter MIN_DATA_DIBITS, default 240: minimum payload dibits (60 bytes) after SFD, excluding FCS.
REQ-002 SHALL have parameter CRC_DIBITS, default 16: FCS length in dibits.
REQ-003 SHALL have parameter MAX_FRAME_DIBITS, default 6072: maximum dibits after SFD, including FCS (1518 bytes).
REQ-004 SHALL have port clk, input, 1: 50 MHz RMII reference clock; one dibit per cycle.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port phy_crsdv, input, 1: RMII carrier sense / data valid.
REQ-007 SHALL have port phy_rxd, input, 2: RMII receive dibit.
REQ-008 SHALL have port axi_valid, output, 1: axi_dout holds a payload dibit; there is no backpressure.
REQ-009 SHALL have port axi_dout, output, 2: payload dibit, in wire order.
REQ-010 SHALL have port axi_last, output, 1: asserted with the final payload dibit of a frame.
REQ-011 SHALL have port frame_ok, output, 1: one-cycle pulse when a frame passes all checks.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse on CRC mismatch, runt, oversize or bad preamble.

Function
REQ-013 SHALL register phy_crsdv and phy_rxd once before use; all outputs SHALL be registered.
REQ-014 SHALL implement states ST_IDLE, ST_PREAMBLE, ST_DATA, ST_CHECK, ST_DROP.
REQ-015 ST_IDLE: crsdv=1 with rxd=01 -> ST_PREAMBLE; crsdv=1 with any other rxd -> ST_DROP; otherwise remain.
REQ-016 ST_PREAMBLE: rxd=01 -> remain; rxd=11 (SFD) -> ST_DATA with counter=0; rxd=00/10 -> ST_DROP with frame_err; crsdv=0 -> ST_IDLE with no pulse.
REQ-017 ST_DATA: each dibit sampled with crsdv=1 SHALL enter a 17-stage delay line and increment the counter.
REQ-018 Once all 17 stages are full, each new dibit SHALL push the oldest dibit out with axi_valid=1, so output latency is 17 dibit-times plus registers.
REQ-019 On the first cycle with crsdv=0 in ST_DATA, the oldest stage SHALL be emitted with axi_valid=1 and axi_last=1; the remaining 16 stages are the FCS; then -> ST_CHECK.
REQ-020 If the frame ends with 17 or fewer dibits held, no axi_last SHALL follow unless stage 17 is occupied; frame_err SHALL pulse (runt).
REQ-021 The counter reaching MAX_FRAME_DIBITS+1 SHALL emit the current output dibit with axi_last=1, pulse frame_err, -> ST_DROP.
REQ-022 ST_CHECK SHALL last exactly CRC_DIBITS cycles and compare the stored FCS dibits, oldest first, against the CRC shift-out dibits.
REQ-023 frame_ok SHALL pulse one cycle after ST_CHECK ends if every FCS dibit matched and counter >= MIN_DATA_DIBITS+CRC_DIBITS; otherwise frame_err SHALL pulse.
REQ-024 After ST_CHECK the block SHALL -> ST_IDLE; phy_crsdv during ST_CHECK SHALL be ignored.
REQ-025 ST_DROP SHALL suppress all outputs until crsdv=0, then -> ST_IDLE.
REQ-026 frame_ok and frame_err SHALL never assert in the same cycle, and at most one of them SHALL pulse per frame.
REQ-027 The CRC SHALL be CRC-32/BZIP2 over payload dibits, including pad, re-initialised on every SFD.

Reset
REQ-028 While reset=1, state=ST_IDLE, counter=0, delay line empty, and axi_valid, axi_dout, axi_last, frame_ok, frame_err all 0.
REQ-029 Reset mid-frame SHALL abort the frame with no axi_last and no pulse; the next frame SHALL require a fresh preamble.

Configuration
REQ-030 With macro MAC_RX_CRC_CHECK_EN defined, CRC checking SHALL run as in REQ-022 and REQ-023.
REQ-031 Without MAC_RX_CRC_CHECK_EN, the CRC instance SHALL be omitted and ST_CHECK SHALL still last CRC_DIBITS cycles; frame_ok/frame_err SHALL then depend only on runt, oversize and preamble checks.

Structure
REQ-032 A shared package mac_pkg SHALL hold the state enum and the constants MIN_DATA_DIBITS, CRC_DIBITS, MAX_FRAME_DIBITS, PREAMBLE_DIBIT (01) and SFD_DIBIT (11).
REQ-033 The CRC SHALL be a single crc32_bzip2 instance (d, d_valid, calc, init, crc) driven by the delay-line output.

Verification
REQ-034 Bench SHALL drive 31x01 + 11 + 240 payload dibits + correct FCS -> 240 axi_valid beats, axi_last on beat 240, frame_ok 17 cycles after crsdv falls.
REQ-035 Bench SHALL drive the same frame with one FCS dibit flipped -> identical axi stream, frame_err pulse, no frame_ok.
REQ-036 Bench SHALL drive 100 payload dibits + valid FCS -> 100 beats with last, frame_err (runt).
REQ-037 Bench SHALL drive 7000 dibits after SFD -> axi_last at beat 6056, frame_err, no output until crsdv=0 and a new preamble.
REQ-038 Bench SHALL drive preamble 01,01,10 -> frame_err, zero axi_valid beats for the whole burst.
REQ-039 Bench SHALL assert reset at payload dibit 50, then send a valid 240-dibit frame -> no last or pulse for the first frame; second frame frame_ok.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the RMII receive MAC: state encoding, frame limits,
// preamble/SFD dibits and the CRC-32/BZIP2 single-bit update.
package mac_pkg;

    localparam int          MIN_DATA_DIBITS  = 240;
    localparam int          CRC_DIBITS       = 16;
    localparam int          MAX_FRAME_DIBITS = 6072;
    localparam logic [1:0]  PREAMBLE_DIBIT   = 2'b01;
    localparam logic [1:0]  SFD_DIBIT        = 2'b11;
    localparam logic [31:0] CRC_POLY         = 32'h04C1_1DB7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_CHECK,
        ST_DROP
    } mac_state_t;

    // Non-reflected (MSB-first) CRC update for one bit.
    function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? CRC_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_bzip2.sv
// Dibit-serial CRC-32/BZIP2 engine, only built with MAC_RX_CRC_CHECK_EN defined.
// calc=1 folds d into the CRC (d[1] first); calc=0 shifts the result out two bits at a time.
`ifdef MAC_RX_CRC_CHECK_EN
module crc32_bzip2 (
    input  logic        clk,
    input  logic [1:0]  d,
    input  logic        d_valid,
    input  logic        calc,
    input  logic        init,
    output logic [31:0] crc
);
    import mac_pkg::*;

    logic [31:0] crc_reg;
    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc_reg;
        if (calc) begin
            crc_next = crc32_step(crc32_step(crc_reg, d[1]), d[0]);
        end else begin
            // Fill with ones so the inverted output reads zero once fully drained.
            crc_next = {crc_reg[29:0], 2'b11};
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            crc_reg <= '1;
        end else if (d_valid) begin
            crc_reg <= crc_next;
        end
    end

    assign crc = ~crc_reg;

endmodule
`endif

// File: rtl/mac_rx.sv
// RMII receive MAC: preamble/SFD hunt, FCS-stripping delay line, runt/oversize checks.
// Define MAC_RX_CRC_CHECK_EN to add the CRC-32/BZIP2 FCS comparison.
module mac_rx #(
    parameter int MIN_DATA_DIBITS  = mac_pkg::MIN_DATA_DIBITS,
    parameter int CRC_DIBITS       = mac_pkg::CRC_DIBITS,
    parameter int MAX_FRAME_DIBITS = mac_pkg::MAX_FRAME_DIBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               phy_crsdv,
    input  logic [1:0]         phy_rxd,
    output logic               axi_valid,
    output logic [1:0]         axi_dout,
    output logic               axi_last,
    output logic               frame_ok,
    output logic               frame_err,
    output mac_pkg::mac_state_t state_dbg
);
    import mac_pkg::*;

    localparam int STAGES = CRC_DIBITS + 1;
    localparam int CNT_W  = $clog2(MAX_FRAME_DIBITS + 2);
    localparam int CHK_W  = $clog2(CRC_DIBITS + 1);

    logic             crs_q;
    logic [1:0]       rxd_q;
    mac_state_t       state;
    mac_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [CHK_W-1:0] check_cnt;
    logic [1:0]       line [STAGES];
    logic             fcs_ok;
    logic             crc_match;
    logic             line_full;
    logic             shift;
    logic             take;
    logic             sfd_seen;
    logic             valid_next;
    logic             last_next;
    logic             ok_next;
    logic             err_next;

    assign line_full = (count >= CNT_W'(STAGES));
    assign state_dbg = state;

`ifdef MAC_RX_CRC_CHECK_EN
    logic [31:0] crc;
    logic        crc_valid;

    assign crc_valid = ((state == ST_DATA) && valid_next) || (state == ST_CHECK);

    crc32_bzip2 u_crc (
        .clk     (clk),
        .d       (line[STAGES-1]),
        .d_valid (crc_valid),
        .calc    (state == ST_DATA),
        .init    (reset || sfd_seen),
        .crc     (crc)
    );

    assign crc_match = (line[STAGES-1] == crc[31:30]);
`else
    assign crc_match = 1'b1;
`endif

    always_comb begin
        state_next = state;
        valid_next = 1'b0;
        last_next  = 1'b0;
        ok_next    = 1'b0;
        err_next   = 1'b0;
        shift      = 1'b0;
        take       = 1'b0;
        sfd_seen   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (crs_q) begin
                    state_next = (rxd_q == PREAMBLE_DIBIT) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!crs_q) begin
                    state_next = ST_IDLE;
                end else if (rxd_q == SFD_DIBIT) begin
                    state_next = ST_DATA;
                    sfd_seen   = 1'b1;
                end else if (rxd_q != PREAMBLE_DIBIT) begin
                    state_next = ST_DROP;
                    err_next   = 1'b1;
                end
            end
            ST_DATA: begin
                shift      = 1'b1;
                valid_next = line_full;
                if (!crs_q) begin
                    // Oldest stage is the final payload dibit; the rest is FCS.
                    last_next  = line_full;
                    state_next = ST_CHECK;
                end else begin
                    take = 1'b1;
                    if (count == CNT_W'(MAX_FRAME_DIBITS)) begin
                        last_next  = 1'b1;
                        err_next   = 1'b1;
                        state_next = ST_DROP;
                    end
                end
            end
            ST_CHECK: begin
                shift = 1'b1;
                if (check_cnt == CHK_W'(CRC_DIBITS - 1)) begin
                    state_next = ST_IDLE;
                    if (fcs_ok && crc_match &&
                        count >= CNT_W'(MIN_DATA_DIBITS + CRC_DIBITS)) begin
                        ok_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!crs_q) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crs_q     <= 1'b0;
            rxd_q     <= 2'b00;
            state     <= ST_IDLE;
            count     <= '0;
            check_cnt <= '0;
            fcs_ok    <= 1'b1;
            axi_valid <= 1'b0;
            axi_dout  <= 2'b00;
            axi_last  <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            crs_q     <= phy_crsdv;
            rxd_q     <= phy_rxd;
            state     <= state_next;
            if (sfd_seen) begin
                count <= '0;
            end else if (take) begin
                count <= count + 1'b1;
            end
            check_cnt <= (state == ST_CHECK) ? check_cnt + 1'b1 : '0;
            fcs_ok    <= (state == ST_CHECK) ? (fcs_ok & crc_match) : 1'b1;
            axi_valid <= valid_next;
            axi_dout  <= valid_next ? line[STAGES-1] : 2'b00;
            axi_last  <= last_next;
            frame_ok  <= ok_next;
            frame_err <= err_next;
        end
    end

    // line[0] is the newest dibit, line[STAGES-1] the oldest.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                line[i] <= 2'b00;
            end
        end else if (shift) begin
            line[0] <= rxd_q;
            for (int i = 1; i < STAGES; i++) begin
                line[i] <= line[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mac_rx.sv
// Bench for mac_rx: frame-level model (payload beats, FCS check, runt/oversize rules)
// checked against the DUT stream by a negedge monitor, plus literal pins of the model.
module tb_mac_rx;

    localparam int MIN_D = 240;
    localparam int CRC_D = 16;
    localparam int MAX_D = 6072;
`ifdef MAC_RX_CRC_CHECK_EN
    localparam int FLIP_OK = 0;
`else
    localparam int FLIP_OK = 1;
`endif

    logic                clk = 1'b0;
    logic                reset;
    logic                phy_crsdv;
    logic [1:0]          phy_rxd;
    logic                axi_valid;
    logic [1:0]          axi_dout;
    logic                axi_last;
    logic                frame_ok;
    logic                frame_err;
    mac_pkg::mac_state_t state_dbg;

    int checks   = 0;
    int failures = 0;

    // Model state: expected beats as {last, dout}, expected and observed verdicts.
    logic [2:0] exp_q[$];
    logic [1:0] post_q[$];
    logic [1:0] crc_in[$];
    int         exp_ok;
    int         exp_err;
    int         obs_ok;
    int         obs_err;
    int         beats;
    int         last_beat;
    bit         strict;
    logic [2:0] mon_e;
    logic [7:0] pin_byte;

    mac_rx dut (
        .clk       (clk),
        .reset     (reset),
        .phy_crsdv (phy_crsdv),
        .phy_rxd   (phy_rxd),
        .axi_valid (axi_valid),
        .axi_dout  (axi_dout),
        .axi_last  (axi_last),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_calc();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (crc_in[i]) begin
            for (int b = 1; b >= 0; b--) begin
                fb = c[31] ^ crc_in[i][b];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
            end
        end
        return ~c;
    endfunction

    function automatic bit fcs_matches(input int nb);
`ifdef MAC_RX_CRC_CHECK_EN
        logic [31:0] c;
        crc_in.delete();
        for (int i = 0; i < nb; i++) crc_in.push_back(post_q[i]);
        c = crc_calc();
        for (int k = 0; k < CRC_D; k++) begin
            if (post_q[nb + k] != c[31 - 2*k -: 2]) return 1'b0;
        end
        return 1'b1;
`else
        return nb >= 0;
`endif
    endfunction

    // Random payload followed by its correct FCS, MSB dibit of the CRC first.
    task automatic build_frame(input int npay);
        logic [31:0] c;
        logic [1:0]  d;
        post_q.delete();
        crc_in.delete();
        for (int i = 0; i < npay; i++) begin
            d = 2'($urandom_range(0, 3));
            post_q.push_back(d);
            crc_in.push_back(d);
        end
        c = crc_calc();
        for (int k = 0; k < CRC_D; k++) post_q.push_back(c[31 - 2*k -: 2]);
    endtask

    // Expected output for the dibits after SFD in post_q.
    task automatic build_expect(output int nb);
        int n;
        n = post_q.size();
        exp_q.delete();
        exp_ok  = 0;
        exp_err = 0;
        if (n > MAX_D) begin
            nb      = MAX_D - CRC_D;
            exp_err = 1;
        end else if (n > CRC_D) begin
            nb = n - CRC_D;
            if (n >= MIN_D + CRC_D && fcs_matches(nb)) exp_ok = 1;
            else exp_err = 1;
        end else begin
            nb      = 0;
            exp_err = 1;
        end
        for (int i = 0; i < nb; i++) exp_q.push_back({i == nb - 1, post_q[i]});
    endtask

    task automatic clear_obs();
        beats     = 0;
        last_beat = 0;
        obs_ok    = 0;
        obs_err   = 0;
    endtask

    task automatic drive(input logic crs, input logic [1:0] d);
        @(posedge clk);
        #1;
        phy_crsdv = crs;
        phy_rxd   = d;
    endtask

    task automatic play_frame();
        for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        foreach (post_q[i]) drive(1'b1, post_q[i]);
        drive(1'b0, 2'b00);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_axi_valid"}, {31'd0, axi_valid}, 32'd0);
        check({tag, "_axi_dout"},  {30'd0, axi_dout},  32'd0);
        check({tag, "_axi_last"},  {31'd0, axi_last},  32'd0);
        check({tag, "_frame_ok"},  {31'd0, frame_ok},  32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(mac_pkg::ST_IDLE));
    endtask

    task automatic run_frame(input string tag, input bit measure, input int nb_lit,
                             input int ok_lit, input int err_lit);
        int nb;
        int k;
        build_expect(nb);
        check({tag, "_model_beats"}, nb, nb_lit);
        check({tag, "_model_ok"}, exp_ok, ok_lit);
        check({tag, "_model_err"}, exp_err, err_lit);
        clear_obs();
        play_frame();
        if (measure) begin
            // Edges counted from the first edge that samples crsdv low.
            k = 0;
            @(posedge clk);
            while (k < 40) begin
                @(posedge clk);
                #1;
                k++;
                if (frame_ok || frame_err) break;
            end
            check({tag, "_pulse_latency"}, k, 17);
        end
        repeat (40) @(posedge clk);
        check({tag, "_beats_left"}, exp_q.size(), 0);
        check({tag, "_beats"}, beats, nb);
        check({tag, "_last_at"}, last_beat, nb_lit);
        check({tag, "_frame_ok"}, obs_ok, exp_ok);
        check({tag, "_frame_err"}, obs_err, exp_err);
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (axi_valid) begin
                beats++;
                if (axi_last) last_beat = beats;
                if (strict) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL beat_unexpected actual=beat %0d expected=no beat", beats);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check($sformatf("beat%0d", beats), {29'd0, axi_last, axi_dout},
                              {29'd0, mon_e});
                    end
                end
            end
            if (frame_ok || frame_err) begin
                obs_ok  += int'(frame_ok);
                obs_err += int'(frame_err);
                check("pulse_exclusive", {31'd0, frame_ok & frame_err}, 32'd0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        repeat (80000) @(posedge clk);
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset     = 1'b1;
        phy_crsdv = 1'b0;
        phy_rxd   = 2'b00;
        strict    = 1'b1;
        clear_obs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        // Pin the CRC model: CRC-32/BZIP2 check value of "123456789".
        crc_in.delete();
        for (int i = 0; i < 9; i++) begin
            pin_byte = 8'h31 + 8'(i);
            crc_in.push_back(pin_byte[7:6]);
            crc_in.push_back(pin_byte[5:4]);
            crc_in.push_back(pin_byte[3:2]);
            crc_in.push_back(pin_byte[1:0]);
        end
        check("crc_model_pin", crc_calc(), 32'hFC89_1918);

        build_frame(240);
        run_frame("good240", 1'b1, 240, 1, 0);

        post_q[240 + 5] ^= 2'b10;
        run_frame("fcs_flip", 1'b0, 240, FLIP_OK, 1 - FLIP_OK);

        build_frame(100);
        run_frame("runt100", 1'b0, 100, 0, 1);

        build_frame(1);
        run_frame("runt17", 1'b0, 1, 0, 1);

        build_frame(0);
        run_frame("runt16", 1'b0, 0, 0, 1);

        post_q.delete();
        for (int i = 0; i < 7000; i++) post_q.push_back(2'($urandom_range(0, 3)));
        run_frame("oversize", 1'b0, 6056, 0, 1);

        build_frame(MAX_D - CRC_D);
        run_frame("max6072", 1'b0, 6056, 1, 0);

        // Bad preamble: the whole burst must be dropped.
        exp_q.delete();
        clear_obs();
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b10);
        drive(1'b1, 2'b11);
        for (int i = 0; i < 40; i++) drive(1'b1, 2'($urandom_range(0, 3)));
        drive(1'b0, 2'b00);
        repeat (40) @(posedge clk);
        check("badpre_beats", beats, 0);
        check("badpre_frame_err", obs_err, 1);
        check("badpre_frame_ok", obs_ok, 0);

        // Reset at payload dibit 50, then a fresh valid frame.
        build_frame(240);
        strict = 1'b0;
        clear_obs();
        for (int i = 0; i < 31; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b11);
        for (int i = 0; i < 50; i++) drive(1'b1, post_q[i]);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        phy_crsdv = 1'b0;
        phy_rxd   = 2'b00;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        check("midreset_last_at", last_beat, 0);
        check("midreset_frame_ok", obs_ok, 0);
        check("midreset_frame_err", obs_err, 0);
        strict = 1'b1;

        build_frame(240);
        run_frame("after_reset", 1'b0, 240, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
